// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: E-stage sequencer for the serial multiplier and owner of
// the HI/LO register pair. It launches one multiply at a time, holds its
// operands until the multiplier completes, writes the product into HI/LO,
// and stalls any E-stage HI/LO user while a multiply is in flight.
module hilo_mult_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MAX_LAT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               multE,
  input  logic               multsignE,
  input  logic               mfhiE,
  input  logic               mfloE,
  input  logic               mthiE,
  input  logic               mtloE,
  input  logic               flushE,
  input  logic [WIDTH-1:0]   srcAE,
  input  logic [WIDTH-1:0]   srcBE,
  output logic               mult_start,
  output logic               mult_sign,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_prod,
  input  logic               mult_valid,
  output logic [WIDTH-1:0]   hilo_rdE,
  output logic               stallMult,
  output logic               busy,
  output logic               timeout
);

  // Counter wide enough to hold MAX_LAT-1; the last legal wait index ends the wait.
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MAX_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [WIDTH-1:0]   mult_b_q, mult_b_d;
  logic               mult_sign_q, mult_sign_d;
  logic               timeout_q, timeout_d;

  logic               any_req_s;
  logic               stall_s;
  logic               acc_s;

  // Stall/accept decode: any live HI/LO user waits while a multiply is in flight.
  always_comb begin
    any_req_s = multE | mfhiE | mfloE | mthiE | mtloE;
    stall_s   = ~flushE & any_req_s & (state_q != S_IDLE);
    acc_s     = ~flushE & ~stall_s;
  end

  // Next-state logic for the sequencer, the latency counter and HI/LO.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    mult_sign_d = mult_sign_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (multE && acc_s) begin
          // A multiply wins over any move issued in the same cycle.
          mult_a_d    = srcAE;
          mult_b_d    = srcBE;
          mult_sign_d = multsignE;
          state_d     = S_START;
        end else begin
          if (mthiE && acc_s) begin
            hi_d = srcAE;
          end else begin
            hi_d = hi_q;
          end
          if (mtloE && acc_s) begin
            lo_d = srcAE;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      S_START: begin
        lat_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (mult_valid) begin
          hi_d    = mult_prod[2*WIDTH-1:WIDTH];
          lo_d    = mult_prod[WIDTH-1:0];
          state_d = S_IDLE;
        end else if (lat_cnt_q == LAT_LAST) begin
          // Multiplier never answered: give up, keep HI/LO as they were.
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      mult_sign_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      mult_sign_q <= mult_sign_d;
      timeout_q   <= timeout_d;
    end
  end

  // Outputs: start is decoded from the START state so it is exactly one cycle wide.
  always_comb begin
    mult_start = (state_q == S_START);
    busy       = (state_q != S_IDLE);
    mult_a     = mult_a_q;
    mult_b     = mult_b_q;
    mult_sign  = mult_sign_q;
    timeout    = timeout_q;
    stallMult  = stall_s;
    hilo_rdE   = mfhiE ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Self-checking bench for hilo_mult_ctrl: directed scenarios plus a random
// phase, all compared against a transaction-level model of HI/LO and of the
// in-flight multiply (age in cycles since acceptance).
module tb_hilo_mult_ctrl;
  localparam int W  = 32;
  localparam int ML = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          multE, multsignE, mfhiE, mfloE, mthiE, mtloE, flushE;
  logic [W-1:0]  srcAE, srcBE;
  logic          mult_start, mult_sign;
  logic [W-1:0]  mult_a, mult_b;
  logic [2*W-1:0] mult_prod;
  logic          mult_valid;
  logic [W-1:0]  hilo_rdE;
  logic          stallMult, busy, timeout;

  hilo_mult_ctrl #(.WIDTH(W), .MAX_LAT(ML)) dut (
    .clk(clk), .rst(rst), .multE(multE), .multsignE(multsignE),
    .mfhiE(mfhiE), .mfloE(mfloE), .mthiE(mthiE), .mtloE(mtloE),
    .flushE(flushE), .srcAE(srcAE), .srcBE(srcBE),
    .mult_start(mult_start), .mult_sign(mult_sign),
    .mult_a(mult_a), .mult_b(mult_b), .mult_prod(mult_prod),
    .mult_valid(mult_valid), .hilo_rdE(hilo_rdE),
    .stallMult(stallMult), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit          m_busy;
  int          m_age;     // 1 = start cycle, >=2 = waiting (index m_age-2)
  logic [31:0] m_a, m_b, m_hi, m_lo;
  bit          m_sign, m_to;
  int          m_lat;     // WAIT cycle (1-based) in which the product arrives
  int          cur_lat;
  bit          spur;
  int          n_start, n_stall;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_a = 32'h0; m_b = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0; m_sign = 1'b0; m_to = 1'b0; m_lat = 1;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic step(input bit mu, input bit sg, input bit fh, input bit fl,
                      input bit th, input bit tl, input bit fe,
                      input logic [31:0] a, input logic [31:0] b);
    bit waiting, vld, exp_stall, acc;
    logic [63:0] p;
    multE = mu; multsignE = sg; mfhiE = fh; mfloE = fl;
    mthiE = th; mtloE = tl; flushE = fe; srcAE = a; srcBE = b;
    waiting = m_busy && (m_age >= 2);
    vld = waiting ? ((m_age - 2) == (m_lat - 1)) : spur;
    p = (vld && waiting) ? ref_prod(m_a, m_b, m_sign) : {$urandom(), $urandom()};
    mult_valid = vld;
    mult_prod = p;
    @(negedge clk);
    exp_stall = !fe && (mu || fh || fl || th || tl) && m_busy;
    if (mult_start) n_start++;
    if (stallMult) n_stall++;
    chk("start", mult_start, m_busy && (m_age == 1));
    chk("busy", busy, m_busy);
    chk("stall", stallMult, exp_stall);
    chk("rd", hilo_rdE, fh ? m_hi : m_lo);
    chk("timeout", timeout, m_to);
    chk("opa", mult_a, m_a);
    chk("opb", mult_b, m_b);
    chk("sign", mult_sign, m_sign);
    acc = !fe && !exp_stall;
    if (m_busy) begin
      if (waiting && vld) begin
        m_hi = p[63:32]; m_lo = p[31:0]; m_busy = 1'b0;
      end else if (waiting && ((m_age - 2) == (ML - 1))) begin
        m_to = 1'b1; m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end else if (mu && acc) begin
      m_busy = 1'b1; m_age = 1; m_a = a; m_b = b; m_sign = sg; m_lat = cur_lat;
    end else begin
      if (th && acc) m_hi = a;
      if (tl && acc) m_lo = a;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    multE = 0; multsignE = 0; mfhiE = 0; mfloE = 0; mthiE = 0; mtloE = 0;
    flushE = 0; mult_valid = 0;
  endtask

  // Read HI and LO with fixed expectations within the current cycle.
  task automatic peek(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    idle_inputs();
    mfhiE = 1'b1;
    #1;
    chk({tag, "_hi"}, hilo_rdE, ehi);
    mfhiE = 1'b0; mfloE = 1'b1;
    #1;
    chk({tag, "_lo"}, hilo_rdE, elo);
    chk({tag, "_nostall"}, stallMult, 1'b0);
    mfloE = 1'b0;
  endtask

  initial begin
    logic [31:0] sv_hi, sv_lo;
    int steps;
    rst = 1'b1;
    idle_inputs();
    srcAE = 32'h0; srcBE = 32'h0; mult_prod = 64'h0;
    spur = 1'b0; cur_lat = 1; n_start = 0; n_stall = 0;
    model_reset();
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", mult_start, 1'b0);
    chk("rst_rd", hilo_rdE, 32'h0);
    chk("rst_to", timeout, 1'b0);
    chk("rst_a", mult_a, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Moves to HI/LO, then reads
    step(0,0,0,0,1,0,0, 32'h12345678, 32'h0);
    step(0,0,0,0,0,1,0, 32'hCAFEBABE, 32'h0);
    step(0,0,1,0,0,0,0, 32'h0, 32'h0);
    step(0,0,0,1,0,0,0, 32'h0, 32'h0);
    peek("t1", 32'h12345678, 32'hCAFEBABE);

    // Signed multiply, mfhi held while busy
    cur_lat = 5; n_start = 0; n_stall = 0;
    step(1,1,0,0,0,0,0, 32'hFFFFFFFD, 32'h7);
    for (int i = 0; i < 40 && m_busy; i++) step(0,0,1,0,0,0,0, 32'h0, 32'h0);
    chk("t2_starts", n_start, 1);
    chk("t2_stalls", n_stall, 6);
    peek("t2", 32'hFFFFFFFF, 32'hFFFFFFEB);

    // Unsigned multiply followed by a back-to-back second multiply
    cur_lat = 2; n_stall = 0;
    step(1,0,0,0,0,0,0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 40 && m_busy; i++) step(1,0,0,0,0,0,0, 32'h3, 32'h5);
    chk("t3_stalls", n_stall, 3);
    peek("t3", 32'hFFFFFFFE, 32'h00000001);
    step(1,0,0,0,0,0,0, 32'h3, 32'h5);
    chk("t3_start2", mult_start, 1'b1);
    chk("t3_a2", mult_a, 32'h3);
    chk("t3_b2", mult_b, 32'h5);
    for (int i = 0; i < 40 && m_busy; i++) step(0,0,0,0,0,0,0, 32'h0, 32'h0);
    peek("t3b", 32'h0, 32'hF);

    // Flushed multiply is ignored
    step(1,0,0,0,1,1,1, 32'h5, 32'h6);
    chk("t4_busy", busy, 1'b0);
    chk("t4_start", mult_start, 1'b0);
    peek("t4", 32'h0, 32'hF);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      cur_lat = $urandom_range(1, 6);
      spur = ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, $urandom(), $urandom());
    end
    spur = 1'b0;
    for (int i = 0; i < 40 && m_busy; i++) step(0,0,0,0,0,0,0, 32'h0, 32'h0);

    // Timeout: multiplier never answers
    chk("t5_to_before", timeout, 1'b0);
    sv_hi = m_hi; sv_lo = m_lo;
    cur_lat = 999; steps = 0;
    step(1,1,0,0,0,0,0, 32'h11, 32'h22);
    for (int i = 0; i < 40 && m_busy; i++) begin
      step(0,0,0,0,0,0,0, 32'h0, 32'h0);
      steps++;
    end
    chk("t5_cycles", steps, 9);
    chk("t5_to", timeout, 1'b1);
    chk("t5_busy", busy, 1'b0);
    peek("t5", sv_hi, sv_lo);
    for (int i = 0; i < 3; i++) step(0,0,0,0,0,0,0, 32'h0, 32'h0);
    chk("t5_sticky", timeout, 1'b1);

    // Asynchronous reset in the middle of WAIT
    cur_lat = 50;
    step(1,1,0,0,0,0,0, 32'hA5A5, 32'h5A);
    step(0,0,0,0,0,0,0, 32'h0, 32'h0);
    step(0,0,0,0,0,0,0, 32'h0, 32'h0);
    step(0,0,0,0,0,0,0, 32'h0, 32'h0);
    mfhiE = 1'b1; mult_valid = 1'b1; mult_prod = 64'h1234_5678_9ABC_DEF0;
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_start", mult_start, 1'b0);
    chk("t6_stall", stallMult, 1'b0);
    chk("t6_rd", hilo_rdE, 32'h0);
    chk("t6_to", timeout, 1'b0);
    chk("t6_a", mult_a, 32'h0);
    chk("t6_b", mult_b, 32'h0);
    chk("t6_sign", mult_sign, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    idle_inputs();
    model_reset();
    spur = 1'b1;
    step(0,0,0,0,0,0,0, 32'h0, 32'h0);
    step(0,0,0,0,0,0,0, 32'h0, 32'h0);
    spur = 1'b0;
    peek("t6", 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_mult_ctrl.md
# hilo_mult_ctrl

Sequencer for the serial multiplier and owner of the HI/LO register pair in the Execute stage of the pipelined MIPS core. It accepts `mult`/`multu`/`mfhi`/`mflo`/`mthi`/`mtlo` requests from E, issues a one-cycle start to `multserial` with held operands, and waits for completion. It then writes the 64-bit product into HI/LO. It stalls the pipeline whenever an E-stage HI/LO user would otherwise read or write stale state, and it flags a multiplier that never completes.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width.
- `MAX_LAT`, default 40: maximum WAIT cycles before timeout.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `multE` in 1: `mult`/`multu` valid in E.
- `multsignE` in 1: 1 = signed (`mult`), 0 = unsigned.
- `mfhiE`, `mfloE`, `mthiE`, `mtloE` in 1 each: HI/LO move request valid in E.
- `flushE` in 1: E instruction is being discarded. All E requests are ignored this cycle.
- `srcAE`, `srcBE` in WIDTH: forwarded E operands. `srcAE` is also the mthi/mtlo data.
- `mult_start` out 1: start pulse to the multiplier.
- `mult_sign` out 1: sign mode to the multiplier, held stable.
- `mult_a`, `mult_b` out WIDTH: captured operands, held stable until completion.
- `mult_prod` in 2*WIDTH: product from the multiplier.
- `mult_valid` in 1: product-valid pulse from the multiplier.
- `hilo_rdE` out WIDTH: HI if `mfhiE`, else LO.
- `stallMult` out 1: freeze F/D/E, insert a bubble into M.
- `busy` out 1: state != IDLE.
- `timeout` out 1: sticky error flag.

## Operation
- State machine: IDLE, START, WAIT.
- Accept condition: `acc = ~flushE & ~stallMult`.
- IDLE, `multE & acc`:
  - Latch `srcAE`→`mult_a`, `srcBE`→`mult_b`, `multsignE`→`mult_sign`.
  - Go to START.
- START:
  - `mult_start`=1 (decoded from state, one cycle only).
  - Clear `lat_cnt`.
  - Go to WAIT.
- WAIT, `mult_valid`=1:
  - HI←`mult_prod[2*WIDTH-1:WIDTH]`, LO←`mult_prod[WIDTH-1:0]`.
  - Go to IDLE.
- WAIT, `mult_valid`=0:
  - Increment `lat_cnt`.
  - When `lat_cnt` reaches MAX_LAT-1 with no valid: set `timeout`, go to IDLE, leave HI/LO unchanged.
- `mult_valid` outside WAIT is ignored.
- `mthiE & acc`: HI←`srcAE`. `mtloE & acc`: LO←`srcAE`. Both may be written in the same cycle.
- Priority when several requests are valid in one cycle: `multE` > `mthiE`/`mtloE`. A `mthi`/`mtlo` that loses to `multE` is dropped.
- `hilo_rdE` is combinational from the current HI/LO registers. A read and a write in the same cycle return the old value.
- Stall rule: `stallMult = ~flushE & (multE|mfhiE|mfloE|mthiE|mtloE) & (state != IDLE)`.
  - Consequence: a HI/LO user in E waits until the state returns to IDLE.
  - The `mult` being accepted never stalls itself.
  - A stalled request is accepted in the first IDLE cycle.
- `timeout` clears only on `rst`.
- Width: product is 2*WIDTH. Sign handling belongs to the multiplier; this block does no arithmetic.

## Timing
- Reset (asynchronous, immediate, no clock edge needed):
  - state=IDLE, HI=LO=0, `lat_cnt`=0.
  - `mult_a`=`mult_b`=0, `mult_sign`=0, `mult_start`=0.
  - `busy`=0, `timeout`=0, `stallMult`=0, `hilo_rdE`=0.
- Cycle sequence for a `mult` request:
  - Cycle 0: `multE` accepted.
  - Cycle 1: START, `mult_start`=1, `busy`=1.
  - Cycle 1+k: WAIT, with k≥1 cycles spent waiting.
  - Edge ending the `mult_valid` cycle: HI/LO written.
  - Next cycle: IDLE, `stallMult` drops, and an E-stage `mfhi` reads the new value.
- Minimum mult-to-usable latency: 3 cycles (START, one WAIT cycle with valid, then IDLE).
- `mult_a`/`mult_b`/`mult_sign` stay constant from cycle 1 until return to IDLE.
- Reset mid-operation: abandons the operation. No HI/LO write occurs even if `mult_valid` arrives with the reset.
- `flushE` during the request cycle: no accept, no stall, no state change.

## Test plan
- Reset, then `mthiE` with `srcAE`=0x12345678, then `mtloE` with 0xCAFEBABE, then `mfhiE` and `mfloE` → `hilo_rdE` = 0x12345678 then 0xCAFEBABE, and `stallMult` stays 0.
- `multE`, `multsignE`=1, A=0xFFFFFFFD, B=7, model valid after 5 WAIT cycles, `mfhiE` held from cycle 1 → `mult_start` is a single pulse in cycle 1, `stallMult`=1 until IDLE, then `hilo_rdE`=0xFFFFFFFF and LO=0xFFFFFFEB.
- `multu` of 0xFFFFFFFF×0xFFFFFFFF followed immediately by a second `multE` → second request stalls until IDLE, HI=0xFFFFFFFE, LO=0x00000001, then the second start issues with the new operands.
- `multE` with `flushE`=1 → `busy` stays 0, no `mult_start`, HI/LO unchanged.
- MAX_LAT=8, `mult_valid` never asserted → `timeout`=1 after 8 WAIT cycles, state IDLE, HI/LO unchanged, `timeout` persists until `rst`.
- Assert `rst` mid-WAIT between clock edges → all outputs at reset values immediately, and a later `mult_valid` pulse writes nothing.
